// File: rtl/imm_extend_pipe_if.sv
// Handshake and data bundle between decode and the registered immediate extender.
interface imm_extend_pipe_if #(
   parameter int unsigned INSTR_W = 34,
   parameter int unsigned XLEN    = 24
);
   logic [INSTR_W-1:0] In;
   logic [1:0]         ImmSrc;
   logic               ZeroExt;
   logic               in_valid;
   logic               in_ready;
   logic               flush;
   logic [XLEN-1:0]    Imm_Ext;
   logic               out_valid;
   logic               out_ready;
   logic               pfx_pending;
   logic               pfx_err;

   // Decode/consumer side: drives instructions, accepts immediates.
   modport master (
      output In, ImmSrc, ZeroExt, in_valid, flush, out_ready,
      input  in_ready, Imm_Ext, out_valid, pfx_pending, pfx_err
   );

   // Extender side.
   modport slave (
      input  In, ImmSrc, ZeroExt, in_valid, flush, out_ready,
      output in_ready, Imm_Ext, out_valid, pfx_pending, pfx_err
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with prefix mode: a prefix instruction latches upper
// immediate bits that are concatenated above the next A/B/C field before extension.
module imm_extend_pipe #(
   parameter int unsigned INSTR_W = 34,
   parameter int unsigned XLEN    = 24,
   parameter int unsigned IMM_A_W = 10,
   parameter int unsigned IMM_B_W = 16,
   parameter int unsigned IMM_C_W = 2,
   parameter int unsigned PFX_W   = 14
) (
   input logic              clk,
   input logic              rst_n,
   imm_extend_pipe_if.slave bus
);

   // Wide enough for {prefix, any field} since every field is at most XLEN bits.
   localparam int unsigned WideW = PFX_W + XLEN;

   localparam logic [1:0] SrcA   = 2'b00;
   localparam logic [1:0] SrcB   = 2'b01;
   localparam logic [1:0] SrcC   = 2'b10;
   localparam logic [1:0] SrcPfx = 2'b11;

   logic [XLEN-1:0]  imm_q, imm_d;
   logic             valid_q, valid_d;
   logic [PFX_W-1:0] pfx_q, pfx_d;
   logic             pend_q, pend_d;
   logic             err_q, err_d;

   logic             in_ready;
   logic             accept;
   logic             is_pfx;
   logic [WideW-1:0] fld;
   logic [WideW-1:0] cat;
   logic [WideW-1:0] lo_mask;
   logic             msb;
   int unsigned      fw;
   int unsigned      cw;
   logic [XLEN-1:0]  imm_ext;

   // Bits of In above the widest field are ignored by design.
   logic unused_in;
   assign unused_in = ^bus.In;

   assign in_ready = !valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   assign is_pfx   = (bus.ImmSrc == SrcPfx);

   // Select the field, optionally glue the pending prefix above it, then extend from its MSB.
   always_comb begin
      fld = '0;
      fw  = IMM_A_W;
      unique case (bus.ImmSrc)
         SrcA: begin
            fld = WideW'(bus.In[IMM_A_W-1:0]);
            fw  = IMM_A_W;
         end
         SrcB: begin
            fld = WideW'(bus.In[IMM_B_W-1:0]);
            fw  = IMM_B_W;
         end
         SrcC: begin
            fld = WideW'(bus.In[IMM_C_W-1:0]);
            fw  = IMM_C_W;
         end
         default: begin
            fld = '0;
            fw  = IMM_A_W;
         end
      endcase
      if (pend_q) begin
         cat = (WideW'(pfx_q) << fw) | fld;
         cw  = fw + PFX_W;
      end else begin
         cat = fld;
         cw  = fw;
      end
      lo_mask = (WideW'(1) << cw) - WideW'(1);
      msb     = |(cat & (WideW'(1) << (cw - 1)));
      // Values wider than XLEN simply lose their top bits through the truncating casts.
      imm_ext = XLEN'(cat & lo_mask) | ((!bus.ZeroExt && msb) ? XLEN'(~lo_mask) : '0);
   end

   // Next-state: drain, prefix load, immediate capture; flush overrides everything.
   always_comb begin
      imm_d   = imm_q;
      valid_d = valid_q;
      pfx_d   = pfx_q;
      pend_d  = pend_q;
      err_d   = 1'b0;
      if (bus.out_ready) begin
         valid_d = 1'b0;
      end
      if (bus.flush) begin
         valid_d = 1'b0;
         pend_d  = 1'b0;
      end else if (accept && is_pfx) begin
         pfx_d  = bus.In[PFX_W-1:0];
         pend_d = 1'b1;
         err_d  = pend_q;
      end else if (accept) begin
         imm_d   = imm_ext;
         valid_d = 1'b1;
         pend_d  = 1'b0;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm_q   <= '0;
         valid_q <= 1'b0;
         pfx_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         imm_q   <= imm_d;
         valid_q <= valid_d;
         pfx_q   <= pfx_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.Imm_Ext     = imm_q;
   assign bus.out_valid   = valid_q;
   assign bus.pfx_pending = pend_q;
   assign bus.pfx_err     = err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe with hand-computed expected immediates.
module tb_imm_extend_pipe;

   logic clk;
   logic rst_n;
   int   total;
   int   passed;

   imm_extend_pipe_if #(.INSTR_W(34), .XLEN(24)) bus ();

   imm_extend_pipe #(
      .INSTR_W(34), .XLEN(24), .IMM_A_W(10), .IMM_B_W(16), .IMM_C_W(2), .PFX_W(14)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input logic [1:0] src, input logic [33:0] word, input logic zext);
      bus.ImmSrc   = src;
      bus.In       = word;
      bus.ZeroExt  = zext;
      bus.in_valid = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total         = 0;
      passed        = 0;
      rst_n         = 1'b0;
      bus.In        = '0;
      bus.ImmSrc    = 2'b00;
      bus.ZeroExt   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      #12;
      check("rst_imm", 32'(bus.Imm_Ext), 32'h0);
      check("rst_valid", 32'(bus.out_valid), 32'h0);
      check("rst_pend", 32'(bus.pfx_pending), 32'h0);
      check("rst_err", 32'(bus.pfx_err), 32'h0);
      rst_n = 1'b1;

      // A field, sign then zero extension
      drive(2'b00, 34'h3F4, 1'b0);
      tick();
      check("a_sext", 32'(bus.Imm_Ext), 32'hFFFFF4);
      check("a_sext_valid", 32'(bus.out_valid), 32'h1);
      drive(2'b00, 34'h3F4, 1'b1);
      tick();
      check("a_zext", 32'(bus.Imm_Ext), 32'h0003F4);
      bus.in_valid = 1'b0;
      tick();
      check("drain_valid", 32'(bus.out_valid), 32'h0);

      // Prefix then A field
      drive(2'b11, 34'h0123, 1'b0);
      tick();
      check("pfx_pend", 32'(bus.pfx_pending), 32'h1);
      check("pfx_novalid", 32'(bus.out_valid), 32'h0);
      drive(2'b00, 34'h005, 1'b0);
      tick();
      check("pfx_a_imm", 32'(bus.Imm_Ext), 32'h048C05);
      check("pfx_a_valid", 32'(bus.out_valid), 32'h1);
      check("pfx_a_pend", 32'(bus.pfx_pending), 32'h0);
      bus.in_valid = 1'b0;
      tick();

      // Prefix with B field (truncated), then C field without prefix
      drive(2'b11, 34'h3FFF, 1'b0);
      tick();
      drive(2'b01, 34'h0001, 1'b0);
      tick();
      check("pfx_b_trunc", 32'(bus.Imm_Ext), 32'hFF0001);
      drive(2'b10, 34'h2, 1'b0);
      tick();
      check("c_sext", 32'(bus.Imm_Ext), 32'hFFFFFE);
      check("c_pend", 32'(bus.pfx_pending), 32'h0);
      bus.in_valid = 1'b0;
      tick();

      // Backpressure: hold for 3 cycles, then release together with a new input
      drive(2'b00, 34'h00C, 1'b0);
      tick();
      check("bp_first", 32'(bus.Imm_Ext), 32'h00000C);
      bus.out_ready = 1'b0;
      drive(2'b00, 34'h011, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_imm", 32'(bus.Imm_Ext), 32'h00000C);
         check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
         check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_ready_comb", 32'(bus.in_ready), 32'h1);
      tick();
      check("bp_next_imm", 32'(bus.Imm_Ext), 32'h000011);
      check("bp_next_valid", 32'(bus.out_valid), 32'h1);
      bus.in_valid = 1'b0;
      tick();
      check("bp_drained", 32'(bus.out_valid), 32'h0);

      // Back-to-back prefixes
      drive(2'b11, 34'h0001, 1'b0);
      tick();
      check("err_first", 32'(bus.pfx_err), 32'h0);
      drive(2'b11, 34'h0002, 1'b0);
      tick();
      check("err_pulse", 32'(bus.pfx_err), 32'h1);
      check("err_pend", 32'(bus.pfx_pending), 32'h1);
      drive(2'b10, 34'h1, 1'b0);
      tick();
      check("err_cleared", 32'(bus.pfx_err), 32'h0);
      check("pfx2_c_imm", 32'(bus.Imm_Ext), 32'h000009);
      check("pfx2_c_pend", 32'(bus.pfx_pending), 32'h0);

      // Flush drops the concurrent input and the pending prefix
      drive(2'b11, 34'h0123, 1'b0);
      tick();
      drive(2'b00, 34'h3F4, 1'b0);
      bus.flush = 1'b1;
      tick();
      check("flush_valid", 32'(bus.out_valid), 32'h0);
      check("flush_pend", 32'(bus.pfx_pending), 32'h0);
      bus.flush = 1'b0;
      drive(2'b00, 34'h005, 1'b0);
      tick();
      check("post_flush_imm", 32'(bus.Imm_Ext), 32'h000005);
      check("post_flush_valid", 32'(bus.out_valid), 32'h1);

      // Asynchronous reset between edges
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_imm", 32'(bus.Imm_Ext), 32'h0);
      check("arst_valid", 32'(bus.out_valid), 32'h0);
      check("arst_pend", 32'(bus.pfx_pending), 32'h0);
      check("arst_err", 32'(bus.pfx_err), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
